// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam int unsigned ADD3_THRESH = 5;

  // Decimal digits needed for 2^width-1: floor(width*log10(2))+1.
  function automatic int bcd_req_digits(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit cell: adds 3 to a BCD digit that is 5 or more (4-bit wrap).
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  digit_t d_i,
  output digit_t d_o
);

  assign d_o = (d_i >= digit_t'(ADD3_THRESH)) ? d_i + digit_t'(3) : d_i;

endmodule

// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD converter, one double-dabble step per clock.
// Define BCD_BLANK_EN to drive blank_mask with leading-zero flags.
module bcd_conv_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH + 1);

  if (DIGITS < bcd_req_digits(WIDTH)) begin : g_bad_digits
    $error("bcd_conv_seq: DIGITS too small to hold 2^WIDTH-1");
  end

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      bin_q, bin_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]         cnt_q, cnt_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_q[4*g +: 4]),
      .d_o (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
      bcd_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          bin_d   = in_bin;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
          cnt_d          = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = out_valid ? bcd_q : '0;

`ifdef BCD_BLANK_EN
  // Walk down from the top digit; digit 0 is never blanked so zero shows "0".
  logic zero_hi;
  always_comb begin
    zero_hi    = 1'b1;
    blank_mask = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_hi       = zero_hi & (out_bcd[4*k +: 4] == 4'd0);
      blank_mask[k] = zero_hi & out_valid;
    end
  end
`else
  assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed + randomized bench for bcd_conv_seq against a decimal reference model.
module tb_bcd_conv_seq;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;
  localparam int LAT    = WIDTH;
  localparam int PERIOD = WIDTH + 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_bin;
  logic                 abort;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*DIGITS-1:0]  out_bcd;
  logic [DIGITS-1:0]    blank_mask;
  logic                 busy;

  int      checks = 0;
  int      errors = 0;
  longint  cyc    = 0;

  bcd_conv_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bin     (in_bin),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bcd    (out_bcd),
    .blank_mask (blank_mask),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: peel decimal digits with %10 and /10.
  function automatic logic [4*DIGITS-1:0] to_bcd(input longint unsigned v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] exp_blank(input longint unsigned v);
    logic [DIGITS-1:0] m;
    int ndig;
    m = '0;
`ifdef BCD_BLANK_EN
    ndig = 1;
    while (v >= 10) begin
      v = v / 10;
      ndig++;
    end
    for (int k = ndig; k < DIGITS; k++) m[k] = 1'b1;
`else
    ndig = 0;
`endif
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 3 * PERIOD) begin
      tick();
      n++;
    end
  endtask

  task automatic conv(input logic [WIDTH-1:0] v, input string tag);
    int n;
    in_bin   = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_inrdy_busy"}, 64'(in_ready), 64'd0);
    wait_valid(n);
    chk({tag, "_latency"}, 64'(n), 64'(LAT));
    chk({tag, "_bcd"}, 64'(out_bcd), 64'(to_bcd(64'(v))));
    chk({tag, "_blank"}, 64'(blank_mask), 64'(exp_blank(64'(v))));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, 64'(in_ready), 64'd1);
    chk({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;
    int hi;
    longint prev;
    logic [WIDTH-1:0] vals [8];

    rst_n = 1'b0; in_valid = 1'b0; in_bin = '0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_bcd", 64'(out_bcd), 64'd0);
    chk("rst_blank", 64'(blank_mask), 64'd0);

    conv(32'd0, "zero");
    conv(32'hFFFF_FFFF, "max");
    chk("max_const", 64'(to_bcd(64'hFFFF_FFFF)), 64'h42_9496_7295);

    // Back-pressure: result must hold for 100 cycles with in_ready low.
    in_bin = 32'd12345; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("bp_latency", 64'(n), 64'(LAT));
    for (int i = 0; i < 100; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_bcd", 64'(out_bcd), 64'h12345);
      chk("bp_inready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_idle", 64'(in_ready), 64'd1);
    chk("bp_release_ov", 64'(out_valid), 64'd0);

    // Back-to-back stream with out_ready held high.
    vals[0] = $urandom;
    vals[1] = 32'($urandom_range(0, 9));
    vals[2] = $urandom;
    vals[3] = 32'($urandom_range(0, 99999));
    vals[4] = 32'd999_999_999;
    vals[5] = $urandom;
    vals[6] = 32'($urandom_range(1000, 1_000_000));
    vals[7] = $urandom;
    prev = 0;
    out_ready = 1'b1;
    in_bin = vals[0];
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_valid(n);
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_bcd", 64'(out_bcd), 64'(to_bcd(64'(vals[i]))));
      chk("stream_blank", 64'(blank_mask), 64'(exp_blank(64'(vals[i]))));
      chk("stream_no_accept_in_done", 64'(in_ready), 64'd0);
      if (i > 0) chk("stream_period", 64'(cyc - prev), 64'(PERIOD));
      prev = cyc;
      if (i < 7) in_bin = vals[i + 1];
      else in_valid = 1'b0;
      tick();
    end
    out_ready = 1'b0;
    chk("stream_end_idle", 64'(in_ready), 64'd1);

    // Abort coincident with in_valid: value is not taken.
    in_bin = 32'd55; in_valid = 1'b1; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    chk("abort_vs_valid_idle", 64'(in_ready), 64'd1);
    chk("abort_vs_valid_busy", 64'(busy), 64'd0);

    // Abort at cnt=15.
    in_bin = 32'd4_000_000_000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) hi++;
      tick();
    end
    chk("abort_no_valid", 64'(hi), 64'd0);

    // Async reset mid-conversion at cnt=20.
    in_bin = 32'd87_654_321; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    rst_n = 1'b0;
    #2;
    chk("rst_mid_inready", 64'(in_ready), 64'd1);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_ov", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid !== 1'b0) hi++;
    end
    chk("rst_mid_no_valid", 64'(hi), 64'd0);

    conv(32'd1000, "k1000");
    chk("k1000_const", 64'(to_bcd(64'd1000)), 64'h1000);

    // Abort while a result is held in DONE.
    in_bin = 32'd42; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(n);
    chk("done_abort_pre", 64'(out_bcd), 64'h42);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("done_abort_ov", 64'(out_valid), 64'd0);
    chk("done_abort_bcd", 64'(out_bcd), 64'd0);
    chk("done_abort_idle", 64'(in_ready), 64'd1);

    conv(32'd7, "seven");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_conv_seq.md
# bcd_conv_seq

Sequential binary-to-BCD conversion controller for the frequency counter display path. Accepts a WIDTH-bit binary count on a valid/ready handshake and runs the shift-add-3 (double-dabble) algorithm one bit per clock. Presents DIGITS packed BCD digits on a second valid/ready handshake. Replaces the single-cycle combinational converter in the readout path, trading a WIDTH-cycle latency for a small, timing-friendly datapath with optional leading-zero blanking.

## Interface
- WIDTH, 32, binary input width
- DIGITS, 10, BCD output digits; must satisfy 10^DIGITS > 2^WIDTH-1, checked at elaboration
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_bin is valid
- in_ready  output  1  block can accept a value
- in_bin  input  WIDTH  binary value
- abort  input  1  synchronous cancel, highest priority after reset
- out_valid  output  1  out_bcd holds a completed result
- out_ready  input  1  consumer takes the result
- out_bcd  output  4*DIGITS  digit k at bits [4k+3:4k], digit 0 is least significant
- blank_mask  output  DIGITS  bit k set means digit k is a leading zero
- busy  output  1  conversion in progress (state SHIFT)

## Operation
- Registers: bin_sr (WIDTH), bcd_sr (4*DIGITS), bit counter cnt (clog2(WIDTH+1) bits), FSM state.
- State IDLE: in_ready=1. When in_valid is high, load bin_sr<=in_bin, clear bcd_sr and cnt, and go to SHIFT.
- State SHIFT, once per cycle:
  - Every digit >=5 adds 3, all digits in parallel, 4-bit wrap (no carry between digits).
  - Then {bcd_sr,bin_sr} shifts left by 1, and cnt increments.
  - When cnt reaches WIDTH-1 on this cycle (the last shift), go to DONE.
- State DONE: out_valid=1. out_bcd=bcd_sr is held stable until out_ready is high, then go to IDLE.
- abort in any state: go to IDLE, clear bcd_sr, out_valid drops next cycle. An abort in the same cycle as in_valid wins, and the value is not accepted.
- in_ready, out_valid and busy decode from state only (no combinational paths from in_valid or out_ready).
- Values are never dropped. Each accepted value produces exactly one result unless aborted.

## Timing
- Reset values:
  - State IDLE, in_ready=1, out_valid=0, busy=0.
  - out_bcd=0 and blank_mask=0 while out_valid=0.
- Latency: value accepted at edge E, so out_valid is high from edge E+WIDTH.
- Throughput: one conversion per WIDTH+2 cycles when out_ready is held high (accept, WIDTH shifts, consume). No overlap of accept with DONE.
- Back-pressure: DONE holds indefinitely, and in_ready stays 0.
- rst_n asserted mid-conversion: immediate return to reset values, partial result discarded.

## Configuration
- BCD_BLANK_EN defined: blank_mask is computed combinationally from the held out_bcd while out_valid=1.
  - Bit k=1 when digit k and all higher digits are zero, for k>=1.
  - Bit 0 is always 0, so the value 0 displays as a single "0".
- BCD_BLANK_EN undefined: blank_mask is tied to 0. The port remains so the display driver interface does not change.

## Structure
- Shared package bcd_pkg holds:
  - digit_t (4-bit logic)
  - FSM state enum (IDLE, SHIFT, DONE)
  - localparam ADD3_THRESH=5
  - function returning the required DIGITS for a given WIDTH, used by the elaboration check
- One sub-module, bcd_digit_adj: a 4-bit add-3-if->=5 cell. It is instantiated DIGITS times by a generate loop.

## Test plan
- After reset release: in_ready=1, out_valid=0, busy=0, out_bcd=0. Then in_bin=0 → after 32 cycles out_bcd=0 and blank_mask=10'h3FE (with BCD_BLANK_EN).
- in_bin=32'hFFFFFFFF → out_bcd digits 9..0 = 4,2,9,4,9,6,7,2,9,5. out_valid first seen exactly 32 edges after acceptance, and blank_mask=0.
- in_bin=12345 with out_ready held low for 100 cycles → out_valid and out_bcd=0x0000012345 stable throughout, in_ready=0. On out_ready the block reaches IDLE next cycle.
- Back-to-back streams of random values with out_ready=1 → every result matches a decimal reference model, one result per 34 cycles.
- abort asserted at cnt=15, then rst_n pulsed at cnt=20 of a second conversion → both return to IDLE with out_valid never asserted. The next conversion of 1000 gives 0x0000001000.
- Build without BCD_BLANK_EN, convert 7 → out_bcd=0x0000000007 and blank_mask=0.
